// File: rtl/oam_dma.sv
// oam_dma: OAM DMA bus initiator, copies XFER_LEN bytes from {page, 8'h00} to DST_BASE, one byte per M-cycle.
// Optional feature macro: OAM_DMA_ECHO_REMAP_EN (echo pages E0..FF fold onto C0..DF as the source page).
package oam_dma_pkg;
  typedef logic [15:0] addr_t;
  typedef logic [7:0]  data_t;
endpackage

module oam_dma
  import oam_dma_pkg::*;
#(
  parameter int unsigned XFER_LEN = 160,
  parameter addr_t       DST_BASE = 16'hFE00,
  parameter int unsigned CPB      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trig,
  input  logic [7:0] trig_page,
  output logic [7:0] dma_reg,
  output logic       active,
  output logic       done,
  output addr_t      mem_r_addr,
  input  data_t      mem_r_data,
  output logic       mem_wen,
  output addr_t      mem_w_addr,
  output data_t      mem_w_data
);

  localparam int unsigned     SUB_W    = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [SUB_W-1:0] SUB_RD  = SUB_W'(CPB - 2);
  localparam logic [SUB_W-1:0] SUB_WR  = SUB_W'(CPB - 1);
  localparam logic [7:0]      IDX_LAST = 8'(XFER_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    XFER
  } state_t;

  state_t           state_q, state_d;
  logic [SUB_W-1:0] sub_q, sub_d;
  logic [7:0]       idx_q, idx_d;
  logic [7:0]       page_q, page_d;
  logic [7:0]       dma_reg_q, dma_reg_d;
  data_t            byte_q, byte_d;
  logic             active_q, active_d;
  logic             done_q, done_d;
  logic             wen_q, wen_d;
  addr_t            r_addr_q, r_addr_d;
  addr_t            w_addr_q, w_addr_d;
  logic [7:0]       eff_page;

`ifdef OAM_DMA_ECHO_REMAP_EN
  assign eff_page = (trig_page[7:5] == 3'b111) ? (trig_page & 8'hDF) : trig_page;
`else
  assign eff_page = trig_page;
`endif

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    sub_d     = sub_q;
    idx_d     = idx_q;
    page_d    = page_q;
    dma_reg_d = dma_reg_q;
    byte_d    = byte_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: ;
      START: begin
        if (sub_q == SUB_WR) begin
          sub_d   = '0;
          state_d = XFER;
        end else begin
          sub_d = sub_q + 1'b1;
        end
      end
      XFER: begin
        if (sub_q == SUB_RD) begin
          byte_d = mem_r_data;
        end
        if (sub_q == SUB_WR) begin
          sub_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          sub_d = sub_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A trigger in any state (re)starts; the write already on the bus this cycle still lands.
    if (trig) begin
      dma_reg_d = trig_page;
      page_d    = eff_page;
      sub_d     = '0;
      idx_d     = '0;
      state_d   = START;
      done_d    = 1'b0;
    end

    // Outputs are registered, so they are derived from the next-state values.
    active_d = (state_d != IDLE);
    wen_d    = (state_d == XFER) && (sub_d == SUB_WR);
    r_addr_d = (state_d == XFER) ? {page_d, idx_d} : r_addr_q;
    w_addr_d = wen_d ? addr_t'(DST_BASE + addr_t'(idx_d)) : w_addr_q;
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sub_q     <= '0;
      idx_q     <= '0;
      page_q    <= '0;
      dma_reg_q <= 8'hFF;
      byte_q    <= '0;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
      wen_q     <= 1'b0;
      r_addr_q  <= '0;
      w_addr_q  <= '0;
    end else begin
      state_q   <= state_d;
      sub_q     <= sub_d;
      idx_q     <= idx_d;
      page_q    <= page_d;
      dma_reg_q <= dma_reg_d;
      byte_q    <= byte_d;
      active_q  <= active_d;
      done_q    <= done_d;
      wen_q     <= wen_d;
      r_addr_q  <= r_addr_d;
      w_addr_q  <= w_addr_d;
    end
  end

  assign dma_reg    = dma_reg_q;
  assign active     = active_q;
  assign done       = done_q;
  assign mem_wen    = wen_q;
  assign mem_r_addr = r_addr_q;
  assign mem_w_addr = w_addr_q;
  assign mem_w_data = byte_q;

  a_wen_active : assert property (@(posedge clk) disable iff (rst) wen_q |-> active_q);
  a_done_idle  : assert property (@(posedge clk) disable iff (rst) done_q |-> !active_q);

endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: directed table-driven bench for oam_dma with a 64 KiB combinational-read memory model.
module tb_oam_dma;
  import oam_dma_pkg::*;

  localparam int    L       = 160;
  localparam int    C       = 4;
  localparam addr_t DST     = 16'hFE00;
  localparam int    LAST_WR = C * (2 + L - 1);
  localparam int    DONE_K  = LAST_WR + 1;

  logic       clk = 1'b0;
  logic       rst, trig, init_req;
  logic [7:0] trig_page, dma_reg;
  logic       active, done, mem_wen;
  addr_t      mem_r_addr, mem_w_addr;
  data_t      mem_r_data, mem_w_data;
  logic [7:0] mem [65536];
  int         n_checks = 0;
  int         n_errors = 0;

  typedef struct {
    logic [7:0] pg;
    logic [7:0] src;
  } vec_t;
  vec_t vecs [6];

  always #5 clk = ~clk;

  oam_dma #(.XFER_LEN(L), .DST_BASE(DST), .CPB(C)) dut (
    .clk(clk), .rst(rst), .trig(trig), .trig_page(trig_page), .dma_reg(dma_reg),
    .active(active), .done(done), .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data),
    .mem_wen(mem_wen), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data)
  );

  function automatic logic [7:0] f(input logic [15:0] a);
    return a[7:0] ^ 8'h5A ^ (a[15:8] - 8'hC0);
  endfunction

  assign mem_r_data = mem[mem_r_addr];

  always @(posedge clk) begin
    if (init_req) begin
      for (int a = 0; a < 65536; a++) mem[a] <= f(16'(a));
    end else if (mem_wen) begin
      mem[mem_w_addr] <= mem_w_data;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_init();
    @(negedge clk);
    init_req = 1'b1;
    @(posedge clk);
    #1 init_req = 1'b0;
  endtask

  task automatic kick(input logic [7:0] pg);
    @(negedge clk);
    trig      = 1'b1;
    trig_page = pg;
  endtask

  // Cycle-accurate watch of one transfer from cycle k0..k1; optionally fires trig/rst at cycle act_at.
  task automatic watch(input logic [7:0] src, input logic [7:0] pg, input int k0, input int k1,
                       input int act_at, input bit act_rst, input logic [7:0] act_pg, input string tag);
    int    e_act = 0, e_done = 0, e_wen = 0, e_data = 0, e_reg = 0;
    bit    wen_exp;
    int    i;
    addr_t ra;
    for (int k = k0; k <= k1; k++) begin
      @(posedge clk);
      #1 trig = 1'b0;
      if (active !== (k <= LAST_WR)) e_act++;
      if (done !== (k == DONE_K)) e_done++;
      if (dma_reg !== pg) e_reg++;
      wen_exp = (k % C == 0) && (k >= 2 * C) && (k <= LAST_WR);
      if (mem_wen !== wen_exp) e_wen++;
      if (wen_exp) begin
        i  = k / C - 2;
        ra = {src, 8'(i)};
        if (mem_w_addr !== DST + 16'(i) || mem_w_data !== f(ra) || mem_r_addr !== ra) e_data++;
      end
      if (k == act_at) begin
        if (act_rst) rst = 1'b1;
        else begin
          trig      = 1'b1;
          trig_page = act_pg;
        end
        break;
      end
    end
    check({tag, " active"}, e_act, 0);
    check({tag, " done"}, e_done, 0);
    check({tag, " wen"}, e_wen, 0);
    check({tag, " wdata"}, e_data, 0);
    check({tag, " dma_reg"}, e_reg, 0);
  endtask

  task automatic check_dest(input logic [7:0] src, input int lo, input int hi, input string tag);
    int e = 0;
    for (int i = lo; i < hi; i++) if (mem[DST + 16'(i)] !== f({src, 8'(i)})) e++;
    check({tag, " dest"}, e, 0);
  endtask

  initial begin
    rst = 1'b1; trig = 1'b0; trig_page = 8'h00; init_req = 1'b0;
    vecs[0] = '{pg: 8'hC0, src: 8'hC0};
    vecs[1] = '{pg: 8'h00, src: 8'h00};
    vecs[2] = '{pg: 8'hDF, src: 8'hDF};
`ifdef OAM_DMA_ECHO_REMAP_EN
    vecs[3] = '{pg: 8'hE1, src: 8'hC1};
    vecs[4] = '{pg: 8'hFE, src: 8'hDE};
    vecs[5] = '{pg: 8'hE0, src: 8'hC0};
`else
    vecs[3] = '{pg: 8'hE1, src: 8'hE1};
    vecs[4] = '{pg: 8'hFE, src: 8'hFE};
    vecs[5] = '{pg: 8'hE0, src: 8'hE0};
`endif

    repeat (3) @(posedge clk);
    #1;
    check("rst active", active, 0);
    check("rst done", done, 0);
    check("rst wen", mem_wen, 0);
    check("rst dma_reg", dma_reg, 8'hFF);
    check("rst r_addr", mem_r_addr, 0);
    check("rst w_addr", mem_w_addr, 0);
    check("rst w_data", mem_w_data, 0);
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      do_init();
      kick(vecs[v].pg);
      watch(vecs[v].src, vecs[v].pg, 1, DONE_K + 3, -1, 1'b0, 8'h00, $sformatf("vec%0d", v));
      check_dest(vecs[v].src, 0, L, $sformatf("vec%0d", v));
      check($sformatf("vec%0d past_end", v), mem[DST + 16'(L)], f(DST + 16'(L)));
    end

    // Restart in the write cycle of byte 50
    do_init();
    kick(8'hC0);
    watch(8'hC0, 8'hC0, 1, DONE_K, C * (2 + 50), 1'b0, 8'hD0, "rs1");
    @(posedge clk);
    #1 trig = 1'b0;
    check("rs byte50", mem[DST + 16'd50], f(16'hC032));
    check("rs active", active, 1);
    check("rs no_done", done, 0);
    check("rs wen", mem_wen, 0);
    check("rs dma_reg", dma_reg, 8'hD0);
    watch(8'hD0, 8'hD0, 2, DONE_K + 3, -1, 1'b0, 8'h00, "rs2");
    check_dest(8'hD0, 0, L, "rs2");

    // Trigger coincident with the final write
    do_init();
    kick(8'hC0);
    watch(8'hC0, 8'hC0, 1, DONE_K, LAST_WR, 1'b0, 8'hC0, "lw1");
    @(posedge clk);
    #1 trig = 1'b0;
    check("lw last_byte", mem[DST + 16'(L - 1)], f({8'hC0, 8'(L - 1)}));
    check("lw no_done", done, 0);
    check("lw active", active, 1);
    check("lw wen", mem_wen, 0);
    watch(8'hC0, 8'hC0, 2, DONE_K + 3, -1, 1'b0, 8'h00, "lw2");

    // Reset during byte 80 (sub 2)
    do_init();
    kick(8'hC0);
    watch(8'hC0, 8'hC0, 1, DONE_K, C * (2 + 80) - 1, 1'b1, 8'h00, "mr");
    @(posedge clk);
    #1 rst = 1'b0;
    check("mr active", active, 0);
    check("mr wen", mem_wen, 0);
    check("mr dma_reg", dma_reg, 8'hFF);
    check("mr done", done, 0);
    check("mr w_addr", mem_w_addr, 0);
    begin
      int e = 0;
      repeat (C * 100) begin
        @(posedge clk);
        #1 if (mem_wen !== 1'b0 || done !== 1'b0 || active !== 1'b0) e++;
      end
      check("mr quiet", e, 0);
    end
    check_dest(8'hC0, 0, 80, "mr written");
    check_dest(8'hFE, 80, L, "mr untouched");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/oam_dma.md
# oam_dma

OAM DMA engine for the SM83 system: the bus-initiator counterpart of the test memory. A CPU write to the DMA page register triggers a copy of `XFER_LEN` bytes from `{page, 8'h00}` to `DST_BASE`, one byte per M-cycle. It drives the memory's read-address and write ports and consumes its combinational read data. `active` tells the arbiter to block CPU bus access.

## Interface
- `XFER_LEN`, 160, bytes per transfer (1..256)
- `DST_BASE`, 16'hFE00, destination base address
- `CPB`, 4, clocks per M-cycle (≥2)

- `clk`  in  1  clock
- `rst`  in  1  reset; one clock, synchronous, active-high
- `trig`  in  1  CPU write strobe to DMA register, single-cycle
- `trig_page`  in  8  source page written with `trig`
- `dma_reg`  out  8  register readback: last written page, unmodified
- `active`  out  1  transfer in progress, including start delay
- `done`  out  1  one-cycle pulse on normal completion
- `mem_r_addr`  out  addr_t  source address
- `mem_r_data`  in  data_t  combinational read data for `mem_r_addr`
- `mem_wen`  out  1  destination write enable
- `mem_w_addr`  out  addr_t  destination address
- `mem_w_data`  out  data_t  destination data

## Operation
- States: IDLE, START, XFER. Counters: `sub` (0..CPB-1), `idx` (0..XFER_LEN-1). Registers: `page`, `byte_q`.
- IDLE + `trig`: `dma_reg`←`trig_page`; `page`←effective page (see Configuration); `sub`←0; `idx`←0; go to START.
- START: lasts one M-cycle (CPB clocks). Then go to XFER.
- XFER, per byte: `mem_r_addr` = `{page, idx}` for the whole M-cycle.
  - At `sub`=CPB-2: `byte_q`←`mem_r_data`.
  - At `sub`=CPB-1: `mem_wen`=1, `mem_w_addr`=DST_BASE+`idx`, `mem_w_data`=`byte_q`.
  - After the write cycle of `idx`=XFER_LEN-1, go to IDLE and pulse `done`.
- `trig` in START/XFER restarts the transfer:
  - Update `dma_reg` and `page`, zero the counters, and enter START.
  - A write in that same cycle still completes.
  - No `done` pulse for the aborted transfer.
- `trig` coincident with the final write: the write completes, START is entered, and `done` is not pulsed.
- `mem_wen` is 0 outside XFER write cycles. Address and data outputs hold their last value when idle.
- Reset values: state IDLE, `active`=0, `done`=0, `mem_wen`=0, `mem_r_addr`=0, `mem_w_addr`=0, `mem_w_data`=0, `dma_reg`=8'hFF.
- `rst` mid-transfer aborts: no further writes, outputs at reset values on the next cycle.
- Address arithmetic is 16-bit and wraps mod 2^16.

## Timing
- All outputs are registered. Cycle k = k rising edges after the edge that samples `trig`.
- `active`=1 from cycle 1. START occupies cycles 1..CPB.
- Byte i occupies cycles 1+CPB(1+i) .. CPB(2+i). `mem_wen` is high only in cycle CPB(2+i).
- `done`=1 and `active`=0 in cycle 1+CPB(1+XFER_LEN). Defaults: last write in cycle 644, `done` in cycle 645.
- Throughput: one write per CPB clocks. Exactly XFER_LEN writes per uninterrupted transfer.
- `mem_r_data` must settle within the same cycle as `mem_r_addr`. It is sampled only at `sub`=CPB-2.

## Configuration
- `OAM_DMA_ECHO_REMAP_EN` defined: a `trig_page` in 8'hE0..8'hFF has bit 5 cleared to form the effective page (E1→C1, FE→DE). `dma_reg` still returns the unmodified value.
- Not defined: effective page = `trig_page` for all values.

## Test plan
- Basic copy: memory[C000+i]=i^8'h5A; `trig` with `trig_page`=C0.
  - Required: 160 writes, FE00+i = i^8'h5A, first write at cycle 8, `done` at cycle 645, `active` high for cycles 1..644.
- Restart: `trig`(C0) followed by `trig`(D0) in the `sub`=CPB-1 cycle of byte 50.
  - Required: the byte-50 write completes with C0 data; FE00..FE9F then end up holding D000..D09F; exactly one `done` pulse, 645 cycles after the second `trig`.
- Reset mid-transfer: assert `rst` during byte 80.
  - Required: next cycle `active`=0, `mem_wen`=0, `dma_reg`=FF; FE50.. unchanged; no `done` pulse.
- Echo remap: `trig_page`=E1.
  - With the macro: reads from C100..C19F.
  - Without the macro: reads from E100..E19F.
  - Both cases: `dma_reg`=E1.
- Trig on the last write: `trig`(C0) coincident with the byte-159 write cycle of a prior transfer.
  - Required: FE9F written, no `done` pulse, new START begins the next cycle.
- Reset/readback: after `rst`, `dma_reg`=FF and all outputs are 0; after `trig`(C0), `dma_reg`=C0 from cycle 1.
